// File: rtl/fold_sched.sv
// fold_sched: round-robin packet scheduler for the shared 16-to-8 XOR fold unit, one signature per packet.
// Optional FOLD_PARITY_EN adds sig_par, the even-parity bit of all accepted packet bits.
module fold_sched #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [31:0]      req_data,
  input  logic [1:0]       req_last,
  output logic [1:0]       req_ready,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [7:0]       sig_data,
  output logic             sig_id,
  output logic [LEN_W-1:0] sig_len,
`ifdef FOLD_PARITY_EN
  output logic             sig_par,
`endif
  output logic             busy
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [7:0] acc_q, acc_d, sig_data_q, sig_data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, sig_len_q, sig_len_d, cnt_inc;
  logic sig_valid_q, sig_valid_d, sig_id_q, sig_id_d;
  logic [15:0] beat_data;
  logic [7:0] fold;
  logic hold, accept;
`ifdef FOLD_PARITY_EN
  logic par_q, par_d, sig_par_q, sig_par_d;
`endif
  assign beat_data = grant_q ? req_data[31:16] : req_data[15:0];
  assign fold = beat_data[7:0] ^ beat_data[15:8];
  assign hold = sig_valid_q && !sig_ready;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign busy = (state_q == BUSY);
  assign sig_valid = sig_valid_q;
  assign sig_data = sig_data_q;
  assign sig_id = sig_id_q;
  assign sig_len = sig_len_q;
`ifdef FOLD_PARITY_EN
  assign sig_par = sig_par_q;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sig_valid_d = sig_valid_q;
    sig_data_d = sig_data_q;
    sig_id_d = sig_id_q;
    sig_len_d = sig_len_q;
    req_ready = '0;
`ifdef FOLD_PARITY_EN
    par_d = par_q;
    sig_par_d = sig_par_q;
`endif
    if (state_q == IDLE) begin
      if (|req_valid) begin
        grant_d = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        state_d = BUSY;
      end
    end else begin
      // a last beat must wait until the output slot can take its signature
      req_ready[grant_q] = !(req_last[grant_q] && hold);
    end
    accept = req_valid[grant_q] && req_ready[grant_q];
    if (sig_valid_q && sig_ready) sig_valid_d = 1'b0;
    if (accept && req_last[grant_q]) begin
      sig_data_d = acc_q ^ fold;
      sig_id_d = grant_q;
      sig_len_d = cnt_inc;
      sig_valid_d = 1'b1;
      acc_d = '0;
      cnt_d = '0;
      rr_ptr_d = ~grant_q;
      state_d = IDLE;
`ifdef FOLD_PARITY_EN
      sig_par_d = par_q ^ (^beat_data);
      par_d = 1'b0;
`endif
    end else if (accept) begin
      acc_d = acc_q ^ fold;
      cnt_d = cnt_inc;
`ifdef FOLD_PARITY_EN
      par_d = par_q ^ (^beat_data);
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      rr_ptr_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      sig_valid_q <= 1'b0;
      sig_data_q <= '0;
      sig_id_q <= 1'b0;
      sig_len_q <= '0;
`ifdef FOLD_PARITY_EN
      par_q <= 1'b0;
      sig_par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sig_valid_q <= sig_valid_d;
      sig_data_q <= sig_data_d;
      sig_id_q <= sig_id_d;
      sig_len_q <= sig_len_d;
`ifdef FOLD_PARITY_EN
      par_q <= par_d;
      sig_par_q <= sig_par_d;
`endif
    end
  end
endmodule

// File: tb/tb_fold_sched.sv
// tb_fold_sched: directed checks of fold_sched (LEN_W=2) with hand-computed signatures.
module tb_fold_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [1:0] req_last = '0;
  logic [1:0] req_ready;
  logic sig_valid;
  logic sig_ready = 1'b1;
  logic [7:0] sig_data;
  logic sig_id;
  logic [1:0] sig_len;
  logic busy;
`ifdef FOLD_PARITY_EN
  logic sig_par;
`endif
  int n_chk = 0;
  int n_fail = 0;

  fold_sched #(.LEN_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .sig_valid(sig_valid),
    .sig_ready(sig_ready), .sig_data(sig_data), .sig_id(sig_id), .sig_len(sig_len),
`ifdef FOLD_PARITY_EN
    .sig_par(sig_par),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // present one beat on requester i and return #1 after the edge that accepted it
  task automatic beat(input int i, input logic [15:0] d, input logic last);
    logic ok;
    ok = 1'b0;
    req_valid[i] = 1'b1;
    req_data[16*i +: 16] = d;
    req_last[i] = last;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = req_ready[i];
      @(posedge clk);
    end
    #1;
    req_valid[i] = 1'b0;
    req_last[i] = 1'b0;
    check("beat_accept_bound", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #2;
    check("rst_ready", {30'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, sig_valid}, 32'd0);
    check("rst_data", {24'd0, sig_data}, 32'd0);
    check("rst_id", {31'd0, sig_id}, 32'd0);
    check("rst_len", {30'd0, sig_len}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single beat
    beat(0, 16'hA55A, 1'b1);
    check("t1_valid", {31'd0, sig_valid}, 32'd1);
    check("t1_data", {24'd0, sig_data}, 32'hFF);
    check("t1_id", {31'd0, sig_id}, 32'd0);
    check("t1_len", {30'd0, sig_len}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
`ifdef FOLD_PARITY_EN
    check("t1_par", {31'd0, sig_par}, 32'd0);
`endif
    @(posedge clk);
    #1;
    check("t1_valid_clear", {31'd0, sig_valid}, 32'd0);
    // two-beat packet on requester 1
    beat(1, 16'h1234, 1'b0);
    check("t2_busy_mid", {31'd0, busy}, 32'd1);
    check("t2_no_sig_mid", {31'd0, sig_valid}, 32'd0);
    beat(1, 16'h00FF, 1'b1);
    check("t2_data", {24'd0, sig_data}, 32'hD9);
    check("t2_id", {31'd0, sig_id}, 32'd1);
    check("t2_len", {30'd0, sig_len}, 32'd2);
`ifdef FOLD_PARITY_EN
    check("t2_par", {31'd0, sig_par}, 32'd1);
`endif
    // simultaneous requests from reset, twice: rr_ptr must return to 0
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      req_valid = 2'b11;
      req_last = 2'b11;
      req_data = 32'h0300_0101;
      @(negedge clk);
      check("t3_idle_ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("t3_ready0", {30'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      check("t3_data0", {24'd0, sig_data}, 32'h00);
      check("t3_id0", {31'd0, sig_id}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("t3_ready1", {30'd0, req_ready}, 32'd2);
      @(posedge clk);
      #1;
      req_valid = '0;
      req_last = '0;
      check("t3_data1", {24'd0, sig_data}, 32'h03);
      check("t3_id1", {31'd0, sig_id}, 32'd1);
    end
    @(posedge clk);
    #1;
    // backpressure on the output slot
    sig_ready = 1'b0;
    beat(0, 16'h00AA, 1'b1);
    check("t4_first_sig", {24'd0, sig_data}, 32'hAA);
    beat(1, 16'h1100, 1'b0);
    req_valid[1] = 1'b1;
    req_last[1] = 1'b1;
    req_data[31:16] = 16'h0022;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_last_held", {30'd0, req_ready}, 32'd0);
      check("t4_hold_valid", {31'd0, sig_valid}, 32'd1);
      check("t4_hold_data", {24'd0, sig_data}, 32'hAA);
      check("t4_hold_id", {31'd0, sig_id}, 32'd0);
    end
    @(posedge clk);
    #1;
    sig_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_release", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_last[1] = 1'b0;
    check("t4_valid", {31'd0, sig_valid}, 32'd1);
    check("t4_data", {24'd0, sig_data}, 32'h33);
    check("t4_id", {31'd0, sig_id}, 32'd1);
    check("t4_len", {30'd0, sig_len}, 32'd2);
    @(posedge clk);
    #1;
    check("t4_clear", {31'd0, sig_valid}, 32'd0);
    // beat-count saturation at 3
    for (int k = 0; k < 4; k++) beat(0, 16'h0001, 1'b0);
    beat(0, 16'h0001, 1'b1);
    check("t5_data", {24'd0, sig_data}, 32'h01);
    check("t5_len", {30'd0, sig_len}, 32'd3);
    check("t5_id", {31'd0, sig_id}, 32'd0);
`ifdef FOLD_PARITY_EN
    check("t5_par", {31'd0, sig_par}, 32'd1);
`endif
    @(posedge clk);
    #1;
    // reset in the middle of a packet
    beat(1, 16'h1234, 1'b0);
    beat(1, 16'h5678, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, sig_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_sig", {31'd0, sig_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    beat(0, 16'h00F0, 1'b1);
    check("t6_valid", {31'd0, sig_valid}, 32'd1);
    check("t6_data", {24'd0, sig_data}, 32'hF0);
    check("t6_len", {30'd0, sig_len}, 32'd1);
    check("t6_id", {31'd0, sig_id}, 32'd0);
`ifdef FOLD_PARITY_EN
    check("t6_par", {31'd0, sig_par}, 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
